// File: rtl/fifo_bridge.sv
// rtl/fifo_bridge.sv - CPU register bridge with IN/OUT FIFOs for the USB CDC byte streams
// IN is written by the CPU and drained by USB, OUT is filled by USB and read by the CPU.
module fifo_bridge #(
   parameter int DATA_W    = 8,
   parameter int IN_DEPTH  = 16,
   parameter int OUT_DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sel_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [1:0]        addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic              in_irq_o,
   output logic              out_irq_o,
   output logic [DATA_W-1:0] in_data_o,
   output logic              in_valid_o,
   input  logic              in_ready_i,
   input  logic [DATA_W-1:0] out_data_i,
   input  logic              out_valid_i,
   output logic              out_ready_o
);
   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam logic [IN_AW:0]  IN_FULL  = (IN_AW+1)'(IN_DEPTH);
   localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW+1)'(OUT_DEPTH);

   logic [DATA_W-1:0] r_in_mem  [IN_DEPTH];
   logic [DATA_W-1:0] r_out_mem [OUT_DEPTH];
   logic [IN_AW-1:0]  r_in_wp, r_in_rp;
   logic [IN_AW:0]    r_in_cnt;
   logic [OUT_AW-1:0] r_out_wp, r_out_rp;
   logic [OUT_AW:0]   r_out_cnt;
   logic              r_in_ovf, r_out_udf;
   logic [7:0]        r_out_thr, r_in_thr;
   logic              r_out_ie, r_in_ie;
   logic [31:0]       r_data;
   logic              r_in_irq, r_out_irq;

   logic        w_wr, w_rd;
   logic        w_in_full, w_in_empty, w_out_full, w_out_empty;
   logic        w_in_push_req, w_in_push, w_in_pop, w_in_flush;
   logic        w_out_push, w_out_pop_req, w_out_pop, w_out_flush;
   logic [7:0]  w_in_free, w_out_lvl, w_in_thr_eff, w_out_thr_eff;
   logic [31:0] w_status, w_ctrl, w_rdata;
   logic        w_unused;

   // A simultaneous read and write performs only the write.
   assign w_wr = sel_i & write_i;
   assign w_rd = sel_i & read_i & ~write_i;

   assign w_in_full   = (r_in_cnt == IN_FULL);
   assign w_in_empty  = (r_in_cnt == '0);
   assign w_out_full  = (r_out_cnt == OUT_FULL);
   assign w_out_empty = (r_out_cnt == '0);

   assign w_in_push_req = w_wr & (addr_i == 2'd0);
   assign w_in_push     = w_in_push_req & ~w_in_full;
   assign w_in_pop      = ~w_in_empty & in_ready_i;
   assign w_in_flush    = w_wr & (addr_i == 2'd3) & data_i[0];
   assign w_out_push    = out_valid_i & ~w_out_full;
   assign w_out_pop_req = w_rd & (addr_i == 2'd0);
   assign w_out_pop     = w_out_pop_req & ~w_out_empty;
   assign w_out_flush   = w_wr & (addr_i == 2'd3) & data_i[1];

   assign w_out_lvl     = 8'(r_out_cnt);
   assign w_in_free     = 8'(IN_DEPTH) - 8'(r_in_cnt);
   assign w_out_thr_eff = (r_out_thr == 8'd0) ? 8'd1 : r_out_thr;
   assign w_in_thr_eff  = (r_in_thr == 8'd0) ? 8'd1 : r_in_thr;

   assign w_status = {8'h00, w_in_free, w_out_lvl, 4'h0, r_out_udf, r_in_ovf, ~w_in_full, ~w_out_empty};
   assign w_ctrl   = {14'h0, r_in_ie, r_out_ie, r_in_thr, r_out_thr};
   assign w_unused = ^data_i;

   always_comb begin
      w_rdata = '0;
      case (addr_i)
         2'd0:    if (!w_out_empty) w_rdata = 32'(r_out_mem[r_out_rp]);
         2'd1:    w_rdata = w_status;
         2'd2:    w_rdata = w_ctrl;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_in_push)  r_in_mem[r_in_wp]   <= data_i[DATA_W-1:0];
      if (w_out_push) r_out_mem[r_out_wp] <= out_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_in_wp  <= '0;
         r_in_rp  <= '0;
         r_in_cnt <= '0;
      end else if (w_in_flush) begin
         r_in_wp  <= '0;
         r_in_rp  <= '0;
         r_in_cnt <= '0;
      end else begin
         if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
         if (w_in_pop)  r_in_rp <= r_in_rp + 1'b1;
         if (w_in_push && !w_in_pop)      r_in_cnt <= r_in_cnt + 1'b1;
         else if (!w_in_push && w_in_pop) r_in_cnt <= r_in_cnt - 1'b1;
      end
   end

   // Flush wins over a same-cycle USB push, discarding that byte.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
      end else if (w_out_flush) begin
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
         if (w_out_pop)  r_out_rp <= r_out_rp + 1'b1;
         if (w_out_push && !w_out_pop)      r_out_cnt <= r_out_cnt + 1'b1;
         else if (!w_out_push && w_out_pop) r_out_cnt <= r_out_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data    <= '0;
         r_in_ovf  <= 1'b0;
         r_out_udf <= 1'b0;
         r_out_thr <= 8'd1;
         r_in_thr  <= 8'd1;
         r_out_ie  <= 1'b0;
         r_in_ie   <= 1'b0;
         r_in_irq  <= 1'b0;
         r_out_irq <= 1'b0;
      end else begin
         if (w_rd) r_data <= w_rdata;
         if (w_in_push_req && w_in_full) r_in_ovf <= 1'b1;
         else if (w_wr && addr_i == 2'd1 && data_i[2]) r_in_ovf <= 1'b0;
         if (w_out_pop_req && w_out_empty) r_out_udf <= 1'b1;
         else if (w_wr && addr_i == 2'd1 && data_i[3]) r_out_udf <= 1'b0;
         if (w_wr && addr_i == 2'd2) begin
            r_out_thr <= data_i[7:0];
            r_in_thr  <= data_i[15:8];
            r_out_ie  <= data_i[16];
            r_in_ie   <= data_i[17];
         end
         r_out_irq <= r_out_ie & (w_out_lvl >= w_out_thr_eff);
         r_in_irq  <= r_in_ie & (w_in_free >= w_in_thr_eff);
      end
   end

   assign data_o      = r_data;
   assign in_irq_o    = r_in_irq;
   assign out_irq_o   = r_out_irq;
   assign in_data_o   = r_in_mem[r_in_rp];
   assign in_valid_o  = ~w_in_empty;
   assign out_ready_o = ~w_out_full;
endmodule

// File: tb/tb_fifo_bridge.sv
// tb/tb_fifo_bridge.sv - self-checking bench for fifo_bridge
// Queue-based reference model stepped once per clock alongside directed and random traffic.
module tb_fifo_bridge;
   localparam int DW    = 8;
   localparam int IN_D  = 16;
   localparam int OUT_D = 16;

   logic          clk_i, rst_i, sel_i, read_i, write_i;
   logic [1:0]    addr_i;
   logic [31:0]   data_i, data_o;
   logic          in_irq_o, out_irq_o, in_valid_o, in_ready_i, out_valid_i, out_ready_o;
   logic [DW-1:0] in_data_o, out_data_i;

   int checks = 0;
   int failures = 0;

   logic [7:0]  q_in[$];
   logic [7:0]  q_out[$];
   bit          m_ovf, m_udf, m_in_irq, m_out_irq;
   logic [31:0] m_ctrl, m_data_o;
   logic [31:0] v;

   fifo_bridge #(.DATA_W(DW), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
      .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .in_irq_o(in_irq_o),
      .out_irq_o(out_irq_o), .in_data_o(in_data_o), .in_valid_o(in_valid_o),
      .in_ready_i(in_ready_i), .out_data_i(out_data_i), .out_valid_i(out_valid_i),
      .out_ready_o(out_ready_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int eff(input int t);
      return (t == 0) ? 1 : t;
   endfunction

   function automatic logic [31:0] m_status();
      int isz = q_in.size();
      int osz = q_out.size();
      return {8'h00, 8'(IN_D - isz), 8'(osz), 4'h0, m_udf, m_ovf, 1'(isz != IN_D), 1'(osz != 0)};
   endfunction

   task automatic model_reset();
      q_in.delete();
      q_out.delete();
      m_ovf = 0; m_udf = 0; m_in_irq = 0; m_out_irq = 0;
      m_ctrl = 32'h0000_0101;
      m_data_o = 32'h0;
   endtask

   task automatic check_outputs();
      check("data_o", data_o, m_data_o);
      check("in_valid", 32'(in_valid_o), 32'(q_in.size() != 0));
      check("out_ready", 32'(out_ready_o), 32'(q_out.size() != OUT_D));
      check("in_irq", 32'(in_irq_o), 32'(m_in_irq));
      check("out_irq", 32'(out_irq_o), 32'(m_out_irq));
      if (q_in.size() != 0) check("in_data", 32'(in_data_o), 32'(q_in[0]));
   endtask

   task automatic idle();
      sel_i = 0; read_i = 0; write_i = 0; addr_i = 2'd0; data_i = 32'h0;
   endtask

   // Apply one clock of the current inputs to the model, advance the DUT, compare.
   task automatic cyc();
      bit rd, wr, nin, nout;
      int isz, osz;
      logic [31:0] rdv;
      rd = sel_i && read_i && !write_i;
      wr = sel_i && write_i;
      isz = q_in.size();
      osz = q_out.size();
      nout = m_ctrl[16] && (osz >= eff(int'(m_ctrl[7:0])));
      nin  = m_ctrl[17] && ((IN_D - isz) >= eff(int'(m_ctrl[15:8])));
      rdv = 32'h0;
      if (rd) begin
         case (addr_i)
            2'd0: rdv = (osz != 0) ? 32'(q_out[0]) : 32'h0;
            2'd1: rdv = m_status();
            2'd2: rdv = m_ctrl;
            default: rdv = 32'h0;
         endcase
         m_data_o = rdv;
      end
      if (isz != 0 && in_ready_i) void'(q_in.pop_front());
      if (wr && addr_i == 2'd0) begin
         if (isz == IN_D) m_ovf = 1;
         else q_in.push_back(data_i[7:0]);
      end
      if (wr && addr_i == 2'd3 && data_i[0]) q_in.delete();
      if (rd && addr_i == 2'd0) begin
         if (osz == 0) m_udf = 1;
         else void'(q_out.pop_front());
      end
      if (out_valid_i && osz != OUT_D) q_out.push_back(out_data_i);
      if (wr && addr_i == 2'd3 && data_i[1]) q_out.delete();
      if (wr && addr_i == 2'd1) begin
         if (data_i[2]) m_ovf = 0;
         if (data_i[3]) m_udf = 0;
      end
      if (wr && addr_i == 2'd2) m_ctrl = data_i & 32'h0003_FFFF;
      m_in_irq = nin;
      m_out_irq = nout;
      @(posedge clk_i);
      #1;
      check_outputs();
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      sel_i = 1; write_i = 1; read_i = 0; addr_i = a; data_i = d;
      cyc();
      idle();
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
      sel_i = 1; read_i = 1; write_i = 0; addr_i = a;
      cyc();
      idle();
      d = data_o;
   endtask

   task automatic do_reset();
      #2 rst_i = 1;
      idle();
      in_ready_i = 0; out_valid_i = 0;
      #1 model_reset();
      check("rst_in_valid", 32'(in_valid_o), 32'h0);
      check("rst_out_ready", 32'(out_ready_o), 32'h1);
      check("rst_data_o", data_o, 32'h0);
      check("rst_irqs", {30'h0, in_irq_o, out_irq_o}, 32'h0);
      #2 rst_i = 0;
      @(posedge clk_i);
      #1 check_outputs();
   endtask

   initial begin
      rst_i = 0;
      idle();
      in_ready_i = 0; out_valid_i = 0; out_data_i = '0;
      #2 rst_i = 1;
      #1 model_reset();
      check("rst_in_valid", 32'(in_valid_o), 32'h0);
      check("rst_out_ready", 32'(out_ready_o), 32'h1);
      check("rst_data_o", data_o, 32'h0);
      check("rst_irqs", {30'h0, in_irq_o, out_irq_o}, 32'h0);
      #3 rst_i = 0;
      @(posedge clk_i);
      #1 check_outputs();
      rd_reg(2'd2, v);
      check("ctrl_reset", v, 32'h0000_0101);

      // IN fill past full, then drain in order
      wr_reg(2'd3, 32'h1);
      wr_reg(2'd1, 32'hC);
      for (int i = 0; i <= 16; i++) wr_reg(2'd0, 32'(i));
      rd_reg(2'd1, v);
      check("in_free_full", 32'(v[23:16]), 32'h0);
      check("in_ovf_set", 32'(v[2]), 32'h1);
      in_ready_i = 1;
      for (int i = 0; i < 16; i++) begin
         check("in_stream", 32'(in_data_o), 32'(i));
         cyc();
      end
      check("in_drained", 32'(in_valid_o), 32'h0);
      in_ready_i = 0;

      // OUT path with underflow
      wr_reg(2'd3, 32'h2);
      wr_reg(2'd1, 32'hC);
      out_valid_i = 1; out_data_i = 8'hA5; cyc();
      out_data_i = 8'h5A; cyc();
      out_valid_i = 0;
      rd_reg(2'd0, v); check("out_rd0", v, 32'hA5);
      rd_reg(2'd0, v); check("out_rd1", v, 32'h5A);
      rd_reg(2'd0, v); check("out_rd_empty", v, 32'h0);
      rd_reg(2'd1, v); check("udf_set", 32'(v[3]), 32'h1);
      wr_reg(2'd1, 32'h8);
      rd_reg(2'd1, v); check("udf_clr", 32'(v[3]), 32'h0);

      // Full boundary: CPU push and USB pop in the same cycle
      wr_reg(2'd3, 32'h1);
      wr_reg(2'd1, 32'h4);
      for (int i = 0; i < 16; i++) wr_reg(2'd0, 32'h20 + 32'(i));
      sel_i = 1; write_i = 1; addr_i = 2'd0; data_i = 32'h77; in_ready_i = 1;
      cyc();
      idle(); in_ready_i = 0;
      rd_reg(2'd1, v);
      check("full_bnd_free", 32'(v[23:16]), 32'h1);
      check("full_bnd_ovf", 32'(v[2]), 32'h1);
      in_ready_i = 1;
      for (int i = 1; i < 16; i++) begin
         check("full_bnd_data", 32'(in_data_o), 32'h20 + 32'(i));
         cyc();
      end
      check("full_bnd_empty", 32'(in_valid_o), 32'h0);
      in_ready_i = 0;

      // OUT level interrupt, threshold 4
      wr_reg(2'd3, 32'h3);
      wr_reg(2'd2, 32'h0001_0004);
      out_valid_i = 1;
      for (int i = 0; i < 3; i++) begin
         out_data_i = 8'($urandom);
         cyc();
         check("irq_below_thr", 32'(out_irq_o), 32'h0);
      end
      out_data_i = 8'h44; cyc();
      check("irq_lag", 32'(out_irq_o), 32'h0);
      out_valid_i = 0; cyc();
      check("irq_set", 32'(out_irq_o), 32'h1);
      rd_reg(2'd0, v);
      check("irq_hold_on_read", 32'(out_irq_o), 32'h1);
      cyc();
      check("irq_clear", 32'(out_irq_o), 32'h0);

      // Flush wins over a concurrent USB push
      out_valid_i = 1; out_data_i = 8'h11; cyc();
      sel_i = 1; write_i = 1; addr_i = 2'd3; data_i = 32'h2; out_data_i = 8'h22;
      cyc();
      idle(); out_valid_i = 0;
      check("flush_ready", 32'(out_ready_o), 32'h1);
      rd_reg(2'd1, v);
      check("flush_cnt", 32'(v[15:8]), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         sel_i   = ($urandom_range(0, 99) < 70);
         read_i  = $urandom_range(0, 1);
         write_i = $urandom_range(0, 1);
         addr_i  = 2'($urandom_range(0, 3));
         if (addr_i == 2'd3 && $urandom_range(0, 7) != 0) addr_i = 2'd0;
         data_i  = $urandom;
         if (addr_i == 2'd2) data_i = $urandom & 32'hFFFF_0F0F;
         in_ready_i  = ($urandom_range(0, 99) < ((i % 300) < 150 ? 15 : 75));
         out_valid_i = ($urandom_range(0, 99) < ((i % 300) < 150 ? 70 : 20));
         out_data_i  = 8'($urandom);
         cyc();
      end
      idle(); in_ready_i = 0; out_valid_i = 0;

      // Reset in the middle of traffic
      wr_reg(2'd2, 32'h0003_0202);
      for (int i = 0; i < 5; i++) begin
         sel_i = 1; write_i = 1; addr_i = 2'd0; data_i = 32'($urandom);
         out_valid_i = 1; out_data_i = 8'($urandom);
         cyc();
      end
      do_reset();
      rd_reg(2'd2, v); check("ctrl_after_rst", v, 32'h0000_0101);
      rd_reg(2'd1, v); check("status_after_rst", v, 32'h0010_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
